risc16_ctrl_fsm: RTL and testbench

Multi-cycle control unit for the RiSC-16 core, directly upstream of the ALU. It fetches each instruction through a valid/ready handshake, decodes it, and drives the ALU's MUX_alu1, MUX_alu2, FUNC_alu and imm controls. It consumes the ALU's EQ and alu_out, sequences data-memory and register-file writeback, and owns the PC.

---
 rtl/risc16_ctrl_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_risc16_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_ctrl_fsm.sv
// risc16_ctrl_fsm - multi-cycle control unit for the RiSC-16 core.
//
// Fetches one instruction word at a time over a valid/ready handshake,
// decodes it, steers the ALU sitting downstream, sequences data-memory
// access and register-file writeback, and owns the program counter.
//
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   instr_valid, instr   instruction word for the current pc
//   instr_ready          high only while waiting for an instruction
//   pc                   current program counter
//   EQ, alu_out          ALU equality flag and result
//   MUX_alu1, MUX_alu2,
//   FUNC_alu, imm        ALU operand selects, function and immediate
//   rf_raddr1/2          register-file read addresses (rB, rC or rA)
//   rf_we/waddr/wdata    register-file write strobe, address and data
//   dmem_req/we/addr     data-memory request, store flag, address
//   dmem_rdata, dmem_ack load data and memory completion
//   halted               core stopped until the next reset
module risc16_ctrl_fsm #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  input  logic            EQ,
  input  logic [15:0]     alu_out,
  output logic            MUX_alu1,
  output logic            MUX_alu2,
  output logic [1:0]      FUNC_alu,
  output logic [9:0]      imm,
  output logic [2:0]      rf_raddr1,
  output logic [2:0]      rf_raddr2,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic [15:0]     rf_wdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [15:0]     dmem_addr,
  input  logic [15:0]     dmem_rdata,
  input  logic            dmem_ack,
  output logic            halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_t;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t          state, state_next;
  logic [15:0]     ir, aluout, mdr;
  logic [PC_W-1:0] pc_next, pc_plus1, br_target;
  opcode_t         op;
  logic [2:0]      ra, rb, rc;
  logic            is_halt;

  assign op = opcode_t'(ir[15:13]);
  assign ra = ir[12:10];
  assign rb = ir[9:7];
  assign rc = ir[2:0];

  // JALR r0,r0 with a nonzero offset is the halt encoding.
  assign is_halt = (ra == 3'd0) && (rb == 3'd0) && (ir[6:0] != 7'd0);

  // Branch target has its own adder because the ALU is busy comparing.
  assign pc_plus1  = pc + PC_ONE;
  assign br_target = pc_plus1 + {{(PC_W-7){ir[6]}}, ir[6:0]};

  // Read addresses come straight from IR so they stay stable from
  // DECODE until the instruction retires.
  assign rf_raddr1   = rb;
  assign rf_raddr2   = ((op == OP_ADD) || (op == OP_NAND)) ? rc : ra;
  assign rf_waddr    = ra;
  assign dmem_addr   = aluout;
  assign instr_ready = (state == FETCH);
  assign halted      = (state == HALT);

  // State, pc and datapath registers; IR, ALUOUT and MDR only load in
  // the one state that owns each of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      aluout <= '0;
      mdr    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if ((state == FETCH) && instr_valid) ir <= instr;
      if (state == EXEC) aluout <= alu_out;
      if ((state == MEM) && dmem_ack && (op == OP_LW)) mdr <= dmem_rdata;
    end
  end

  // Writeback data source depends only on the opcode.
  always_comb begin
    rf_wdata = aluout;
    if (op == OP_LW)        rf_wdata = mdr;
    else if (op == OP_JALR) rf_wdata = pc_plus1;
  end

  // Next-state, next-pc and strobe decode. Every output defaults to its
  // idle value so only the active state has to raise anything.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    MUX_alu1   = 1'b0;
    MUX_alu2   = 1'b0;
    FUNC_alu   = 2'b00;
    imm        = 10'd0;
    rf_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    case (state)
      FETCH: begin
        if (instr_valid) state_next = DECODE;
      end
      DECODE: begin
        state_next = EXEC;
      end
      EXEC: begin
        imm = ir[9:0];
        case (op)
          OP_ADD: begin
            state_next = WB;
          end
          OP_ADDI: begin
            MUX_alu2   = 1'b1;
            state_next = WB;
          end
          OP_NAND: begin
            FUNC_alu   = 2'b01;
            state_next = WB;
          end
          OP_LUI: begin
            FUNC_alu   = 2'b10;
            MUX_alu1   = 1'b1;
            state_next = WB;
          end
          OP_SW, OP_LW: begin
            MUX_alu2   = 1'b1;
            state_next = MEM;
          end
          OP_BEQ: begin
            FUNC_alu   = 2'b11;
            pc_next    = EQ ? br_target : pc_plus1;
            state_next = FETCH;
          end
          OP_JALR: begin
            FUNC_alu   = 2'b10;
            state_next = is_halt ? HALT : WB;
          end
          default: state_next = FETCH;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_SW);
        if (dmem_ack) begin
          if (op == OP_SW) begin
            pc_next    = pc_plus1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        // Writes to r0 are dropped but the instruction still retires.
        rf_we      = (ra != 3'd0);
        pc_next    = (op == OP_JALR) ? aluout[PC_W-1:0] : pc_plus1;
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// tb_risc16_ctrl_fsm - randomized self-checking bench for risc16_ctrl_fsm.
//
// The bench plays instruction memory, ALU and data memory. An
// instruction-level reference model predicts, for every instruction, the
// ALU controls, read addresses, memory access, writeback and the pc that
// follows, and the bench walks the cycles the instruction should take.
module tb_risc16_ctrl_fsm;

  localparam logic [15:0] TB_RESET_PC = 16'hFFFC;

  logic        clk, rst;
  logic        instr_valid, instr_ready;
  logic [15:0] instr, pc;
  logic        EQ;
  logic [15:0] alu_out;
  logic        MUX_alu1, MUX_alu2;
  logic [1:0]  FUNC_alu;
  logic [9:0]  imm;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_rdata;
  logic        halted;

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] model_pc;

  risc16_ctrl_fsm #(.PC_W(16), .RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .pc(pc), .EQ(EQ), .alu_out(alu_out),
    .MUX_alu1(MUX_alu1), .MUX_alu2(MUX_alu2), .FUNC_alu(FUNC_alu), .imm(imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a broken design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst         = 1'b1;
    instr_valid = 1'b0;
    dmem_ack    = 1'b0;
    tick();
    rst      = 1'b0;
    model_pc = TB_RESET_PC;
    checkOutput("rst_ready",  instr_ready, 1);
    checkOutput("rst_pc",     pc, TB_RESET_PC);
    checkOutput("rst_rf_we",  rf_we, 0);
    checkOutput("rst_req",    dmem_req, 0);
    checkOutput("rst_we",     dmem_we, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_alu",    {FUNC_alu, MUX_alu1, MUX_alu2}, 0);
    checkOutput("rst_addr",   dmem_addr, 0);
  endtask

  // Run one instruction through the DUT. rst_at_mem=k asserts reset in
  // the k-th MEM cycle (0 = never). did_halt reports a HALT.
  task automatic applyStimulus(input logic [15:0] ins, input int fetch_wait,
                               input int mem_wait, input logic [15:0] alu_val,
                               input logic eq_val, input logic [15:0] rdata,
                               input int rst_at_mem, output logic did_halt);
    logic [2:0]  op, ra, rb, rc;
    logic [15:0] sext7, exp_wdata;
    logic [1:0]  e_func;
    logic        e_m1, e_m2, uses_rc, is_mem, is_store, is_branch, is_jalr;
    logic [2:0]  e_raddr2;
    op = ins[15:13]; ra = ins[12:10]; rb = ins[9:7]; rc = ins[2:0];
    sext7 = {{9{ins[6]}}, ins[6:0]};
    did_halt = 1'b0;
    e_func = 2'b00; e_m1 = 0; e_m2 = 0; uses_rc = 0;
    is_mem = 0; is_store = 0; is_branch = 0; is_jalr = 0;
    case (op)
      3'd0: uses_rc = 1;
      3'd1: e_m2 = 1;
      3'd2: begin e_func = 2'b01; uses_rc = 1; end
      3'd3: begin e_func = 2'b10; e_m1 = 1; end
      3'd4: begin e_m2 = 1; is_mem = 1; is_store = 1; end
      3'd5: begin e_m2 = 1; is_mem = 1; end
      3'd6: begin e_func = 2'b11; is_branch = 1; end
      default: begin e_func = 2'b10; is_jalr = 1; end
    endcase
    e_raddr2 = uses_rc ? rc : ra;

    for (int i = 0; i < fetch_wait; i++) begin
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      checkOutput("fetch_wait_ready", instr_ready, 1);
      checkOutput("fetch_wait_pc", pc, model_pc);
      tick();
    end
    instr_valid = 1'b1;
    instr       = ins;
    checkOutput("fetch_ready", instr_ready, 1);
    checkOutput("fetch_pc", pc, model_pc);
    tick();
    instr_valid = 1'b0;
    instr       = 16'($urandom);

    checkOutput("dec_ready", instr_ready, 0);
    checkOutput("dec_raddr1", rf_raddr1, rb);
    checkOutput("dec_raddr2", rf_raddr2, e_raddr2);
    checkOutput("dec_strobes", {rf_we, dmem_req, halted}, 0);
    checkOutput("dec_alu", {FUNC_alu, MUX_alu1, MUX_alu2}, 0);
    tick();

    alu_out = alu_val;
    EQ      = eq_val;
    checkOutput("exec_func", FUNC_alu, e_func);
    checkOutput("exec_mux", {MUX_alu1, MUX_alu2}, {e_m1, e_m2});
    checkOutput("exec_imm", imm, ins[9:0]);
    checkOutput("exec_raddr", {rf_raddr1, rf_raddr2}, {rb, e_raddr2});
    checkOutput("exec_strobes", {rf_we, dmem_req, instr_ready}, 0);
    tick();
    alu_out = 16'($urandom);
    EQ      = 1'($urandom);

    if (is_jalr && ra == 0 && rb == 0 && ins[6:0] != 0) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("halt_flag", halted, 1);
        checkOutput("halt_ready", instr_ready, 0);
        checkOutput("halt_pc", pc, model_pc);
        checkOutput("halt_strobes", {rf_we, dmem_req}, 0);
        instr_valid = 1'b1;
        tick();
      end
      instr_valid = 1'b0;
      did_halt    = 1'b1;
      return;
    end

    if (is_branch) begin
      model_pc = eq_val ? model_pc + 16'd1 + sext7 : model_pc + 16'd1;
      checkOutput("beq_rf_we", rf_we, 0);
      return;
    end

    if (is_mem) begin
      for (int k = 0; k <= mem_wait; k++) begin
        checkOutput("mem_req", dmem_req, 1);
        checkOutput("mem_we", dmem_we, is_store);
        checkOutput("mem_addr", dmem_addr, alu_val);
        checkOutput("mem_rf", {rf_we, instr_ready, rf_raddr2}, {2'b00, ra});
        if (rst_at_mem == k + 1) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          model_pc = TB_RESET_PC;
          checkOutput("mrst_req", {dmem_req, dmem_we, rf_we}, 0);
          checkOutput("mrst_ready", instr_ready, 1);
          checkOutput("mrst_pc", pc, TB_RESET_PC);
          return;
        end
        dmem_ack   = (k == mem_wait);
        dmem_rdata = (k == mem_wait) ? rdata : 16'($urandom);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 16'($urandom);
      end
      if (is_store) begin
        model_pc = model_pc + 16'd1;
        checkOutput("sw_done", {rf_we, dmem_req}, 0);
        return;
      end
    end

    exp_wdata = is_mem ? rdata : (is_jalr ? model_pc + 16'd1 : alu_val);
    checkOutput("wb_we", rf_we, (ra != 3'd0));
    checkOutput("wb_waddr", rf_waddr, ra);
    checkOutput("wb_wdata", rf_wdata, exp_wdata);
    checkOutput("wb_other", {dmem_req, instr_ready, FUNC_alu}, 0);
    tick();
    model_pc = is_jalr ? alu_val : model_pc + 16'd1;
    checkOutput("post_wb_we", rf_we, 0);
  endtask

  initial begin
    logic        h;
    logic [15:0] ins;
    int          fw, mw, ra_k;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; EQ = 1'b0;
    alu_out = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    model_pc = TB_RESET_PC;
    repeat (2) @(negedge clk);
    applyReset();

    // Directed cases from the test plan.
    applyStimulus(16'h0482, 0, 0, 16'd30,   1'b0, 16'h0, 0, h);
    applyStimulus(16'h6F33, 1, 0, 16'hCCC0, 1'b0, 16'h0, 0, h);
    applyStimulus(16'hE500, 0, 0, 16'd5,    1'b0, 16'h0, 0, h);
    applyStimulus(16'hC07E, 0, 0, 16'h1234, 1'b1, 16'h0, 0, h);
    checkOutput("beq_taken_pc", pc, 16'd4);
    applyStimulus(16'hE500, 0, 0, 16'd5,    1'b0, 16'h0, 0, h);
    applyStimulus(16'hC07E, 0, 0, 16'h1234, 1'b0, 16'h0, 0, h);
    checkOutput("beq_nt_pc", pc, 16'd6);
    applyStimulus(16'hA883, 0, 2, 16'h0010, 1'b0, 16'hBEEF, 0, h);
    applyStimulus(16'h2005, 0, 0, 16'd5,    1'b0, 16'h0, 0, h);
    applyStimulus(16'hE001, 0, 0, 16'h0100, 1'b0, 16'h0, 0, h);
    checkOutput("jalr_halt", h, 1);
    applyReset();
    applyStimulus(16'h8601, 0, 3, 16'h0200, 1'b0, 16'h0, 2, h);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[12:10] = 3'd0;
      if ($urandom_range(0, 7) == 0) ins[9:7]   = 3'd0;
      fw   = $urandom_range(0, 2);
      mw   = $urandom_range(0, 3);
      ra_k = ($urandom_range(0, 15) == 0) ? $urandom_range(1, mw + 1) : 0;
      applyStimulus(ins, fw, mw, 16'($urandom), 1'($urandom),
                    16'($urandom), ra_k, h);
      if (h) applyReset();
    end
    checkOutput("final_pc", pc, model_pc);
    checkOutput("final_ready", instr_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
